sd_block_xfer: RTL and testbench
================================

// Module: sd_block_xfer
// PURPOSE
//  Parametrised multi-block transfer sequencer; successor to the single-digit read/write control FSM.
//  Sits between user logic and sd_spi_controller. One command reads or writes cmd_count consecutive
//  512-byte blocks starting at BASE_LBA+cmd_lba_off. Writes fill each block with cmd_fill. Reads keep
//  the first CAP_BYTES bytes of the last block in a capture buffer. Adds per-block timeout and byte-count check.
// PARAMETERS
//  BASE_LBA     20          first sector of DATA.BIN (after boot+FAT+rootdir)
//  ADDR_W       11          width of cmd_lba_off (block offset inside DATA.BIN)
//  CNT_W        4           width of cmd_count / blocks_done (max 2^CNT_W-1 blocks per command)
//  CAP_BYTES    16          bytes captured per read block (power of 2, 1..512)
//  TIMEOUT_CYC  50_000_000  max clk cycles from sd_*_start to sd_*_done per block (0.5 s @100 MHz)
// PORTS
//  clk          in   1       system clock, 100 MHz
//  rst_n        in   1       asynchronous, active-low reset
//  cmd_start    in   1       1-cycle request; accepted only in IDLE
//  cmd_write    in   1       1=write, 0=read; sampled with cmd_start
//  cmd_lba_off  in   ADDR_W  starting block offset; sampled with cmd_start
//  cmd_count    in   CNT_W   number of blocks; sampled with cmd_start
//  cmd_fill     in   8       write fill byte; sampled with cmd_start
//  cmd_busy     out  1       high from acceptance until done/err pulse
//  cmd_done     out  1       1-cycle pulse at successful completion
//  cmd_err      out  1       sticky error flag; cleared on next accepted cmd_start
//  err_code     out  3       0 none,1 not-init,2 timeout,3 short block,4 verify mismatch
//  blocks_done  out  CNT_W   blocks completed in current/last command
//  cap_addr     in   $clog2(CAP_BYTES)  capture buffer read address
//  cap_data     out  8       capture buffer data, registered, 1-cycle latency
//  sd_init_done in 1; sd_init_err in 1; sd_busy in 1  status from sd_spi_controller
//  sd_rd_start out 1; sd_rd_addr out 32; sd_rd_data in 8; sd_rd_valid in 1; sd_rd_done in 1
//  sd_wr_start out 1; sd_wr_addr out 32; sd_wr_data out 8; sd_wr_done in 1
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, capture buffer contents undefined. Reset mid-transfer aborts
//   immediately; no start pulse is issued afterwards.
//  States: IDLE -> CHECK -> ISSUE -> WAIT_RD|WAIT_WR -> NEXT -> (ISSUE|DONE); any -> ERR -> IDLE.
//  IDLE: cmd_start latches all cmd_* inputs, clears cmd_err/err_code/blocks_done, sets cmd_busy.
//   cmd_start while cmd_busy is ignored.
//  CHECK: !sd_init_done or sd_init_err -> ERR code 1. cmd_count==0 -> DONE, 0 blocks, no SD access.
//  ISSUE: waits for sd_busy==0, then drives exactly one 1-cycle sd_rd_start or sd_wr_start.
//   addr = BASE_LBA + lba_off + blk_idx; 32-bit, wraps mod 2^32. sd_rd_addr and sd_wr_addr both carry
//   addr. sd_wr_data = latched fill byte, held stable for the whole command.
//  WAIT_RD: each sd_rd_valid increments a 10-bit byte counter. Bytes with index < CAP_BYTES are written
//   to the capture buffer, which is overwritten every block. sd_rd_valid and sd_rd_done in the same
//   cycle: the byte counts before the check. On sd_rd_done, count != 512 -> ERR code 3.
//  WAIT_WR: waits for sd_wr_done.
//  Timeout counter resets at each start pulse. Reaching TIMEOUT_CYC before done -> ERR code 2.
//  NEXT: blocks_done++. blk_idx == count-1 -> DONE, else blk_idx++ and -> ISSUE.
//  DONE: cmd_done pulse, cmd_busy low the same cycle. ERR: cmd_err=1, cmd_busy low, no done pulse.
//  Latency: cmd_start to first sd_*_start = 2 cycles when sd_busy is low.
// CONFIGURATION
//  SD_XFER_VERIFY_EN defined: after each write block, read back the same addr (VERIFY state pair).
//   Every byte must equal the fill byte. First mismatch -> ERR code 4, reached after sd_rd_done.
//   blocks_done increments only after verify passes. Capture buffer is updated by verify reads.
//  Undefined: no readback; a write block completes on sd_wr_done; code 4 is never produced.
// STRUCTURE
//  Package sd_xfer_pkg: state encoding localparams, err_code constants, SECTOR_BYTES=512.
//  Sub-module sd_cap_ram: CAP_BYTES x 8 simple dual-port RAM (1 write, 1 registered read port).
// TESTING
//  read, off=3, count=1, BFM block bytes=i%256 -> one sd_rd_start, addr=23, cap_data[5]=0x05, cmd_done.
//  write, off=0, count=4, fill=0x37 -> 4 sd_wr_start at addr 20..23, sd_wr_data=0x37, blocks_done=4.
//  start with sd_init_done=0 -> no SD start, cmd_err=1, err_code=1 within 3 cycles.
//  BFM never asserts sd_rd_done (TIMEOUT_CYC=1000) -> err_code=2 at cycle 1000, cmd_busy low.
//  BFM sends 511 bytes then sd_rd_done -> err_code=3; rst_n low mid-block -> all outputs 0 immediately.
//  SD_XFER_VERIFY_EN, BFM corrupts byte 100 on readback -> err_code=4, blocks_done=0.

Source files
------------

// File: rtl/sd_xfer_pkg.sv
// Shared definitions for the multi-block SD transfer sequencer:
// state encoding, error codes and sector size.
package sd_xfer_pkg;

    localparam int SECTOR_BYTES = 512;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_CHECK     = 4'd1,
        S_ISSUE     = 4'd2,
        S_WAIT_RD   = 4'd3,
        S_WAIT_WR   = 4'd4,
        S_NEXT      = 4'd5,
        S_DONE      = 4'd6,
        S_ERR       = 4'd7,
        S_VFY_ISSUE = 4'd8,
        S_VFY_WAIT  = 4'd9
    } state_t;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_NOT_INIT = 3'd1;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd2;
    localparam logic [2:0] ERR_SHORT    = 3'd3;
    localparam logic [2:0] ERR_VERIFY   = 3'd4;

endpackage

// File: rtl/sd_cap_ram.sv
// Capture buffer: DEPTH x 8 simple dual-port RAM, one write port and one
// registered read port. Only the read register is reset so the array maps
// onto block/distributed RAM.
module sd_cap_ram #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    // Write port: store captured read bytes.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read port: one cycle latency, output register cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata <= 8'h00;
        else        rdata <= mem[raddr];
    end

endmodule

// File: rtl/sd_block_xfer.sv
// Multi-block SD transfer sequencer sitting between user logic and
// sd_spi_controller. Reads or writes cmd_count consecutive sectors starting
// at BASE_LBA + cmd_lba_off, with per-block timeout and byte-count check.
// Optional macro SD_XFER_VERIFY_EN: read back every written block and
// compare each byte against the fill byte.
module sd_block_xfer
    import sd_xfer_pkg::*;
#(
    parameter int BASE_LBA    = 20,
    parameter int ADDR_W      = 11,
    parameter int CNT_W       = 4,
    parameter int CAP_BYTES   = 16,
    parameter int TIMEOUT_CYC = 50_000_000,
    parameter int CAP_AW      = (CAP_BYTES > 1) ? $clog2(CAP_BYTES) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_start,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_lba_off,
    input  logic [CNT_W-1:0]  cmd_count,
    input  logic [7:0]        cmd_fill,
    output logic              cmd_busy,
    output logic              cmd_done,
    output logic              cmd_err,
    output logic [2:0]        err_code,
    output logic [CNT_W-1:0]  blocks_done,
    input  logic [CAP_AW-1:0] cap_addr,
    output logic [7:0]        cap_data,
    input  logic              sd_init_done,
    input  logic              sd_init_err,
    input  logic              sd_busy,
    output logic              sd_rd_start,
    output logic [31:0]       sd_rd_addr,
    input  logic [7:0]        sd_rd_data,
    input  logic              sd_rd_valid,
    input  logic              sd_rd_done,
    output logic              sd_wr_start,
    output logic [31:0]       sd_wr_addr,
    output logic [7:0]        sd_wr_data,
    input  logic              sd_wr_done
);

    state_t            state_reg;
    logic              write_reg;
    logic [ADDR_W-1:0] lba_off_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  blk_idx_reg;
    logic [9:0]        byte_cnt_reg;
    logic [31:0]       timer_reg;
    logic [31:0]       addr_reg;
`ifdef SD_XFER_VERIFY_EN
    logic              mismatch_reg;
    logic              byte_bad;
`endif

    logic        rd_phase;
    logic        cap_we;
    logic [9:0]  byte_cnt_next;
    logic        timeout_hit;
    logic        last_blk;
    logic [31:0] addr_next;

    assign rd_phase      = (state_reg == S_WAIT_RD) || (state_reg == S_VFY_WAIT);
    assign cap_we        = rd_phase && sd_rd_valid && (byte_cnt_reg < 10'(CAP_BYTES));
    // A byte arriving together with sd_rd_done is counted before the length check.
    assign byte_cnt_next = byte_cnt_reg + 10'(sd_rd_valid);
    assign timeout_hit   = (timer_reg == 32'(TIMEOUT_CYC - 1));
    assign last_blk      = (blk_idx_reg == count_reg - CNT_W'(1));
    assign addr_next     = 32'(BASE_LBA) + 32'(lba_off_reg) + 32'(blk_idx_reg);
`ifdef SD_XFER_VERIFY_EN
    assign byte_bad      = sd_rd_valid && (sd_rd_data != sd_wr_data);
`endif

    assign sd_rd_addr = addr_reg;
    assign sd_wr_addr = addr_reg;

    sd_cap_ram #(
        .DEPTH (CAP_BYTES),
        .AW    (CAP_AW)
    ) u_cap_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (cap_we),
        .waddr (byte_cnt_reg[CAP_AW-1:0]),
        .wdata (sd_rd_data),
        .raddr (cap_addr),
        .rdata (cap_data)
    );

    // Sequencer FSM with registered outputs; errors jump to ERR with busy dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            write_reg    <= 1'b0;
            lba_off_reg  <= '0;
            count_reg    <= '0;
            blk_idx_reg  <= '0;
            byte_cnt_reg <= '0;
            timer_reg    <= '0;
            addr_reg     <= '0;
`ifdef SD_XFER_VERIFY_EN
            mismatch_reg <= 1'b0;
`endif
            cmd_busy     <= 1'b0;
            cmd_done     <= 1'b0;
            cmd_err      <= 1'b0;
            err_code     <= ERR_NONE;
            blocks_done  <= '0;
            sd_rd_start  <= 1'b0;
            sd_wr_start  <= 1'b0;
            sd_wr_data   <= 8'h00;
        end else begin
            sd_rd_start <= 1'b0;
            sd_wr_start <= 1'b0;
            cmd_done    <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (cmd_start) begin
                        write_reg   <= cmd_write;
                        lba_off_reg <= cmd_lba_off;
                        count_reg   <= cmd_count;
                        sd_wr_data  <= cmd_fill;
                        blk_idx_reg <= '0;
                        cmd_err     <= 1'b0;
                        err_code    <= ERR_NONE;
                        blocks_done <= '0;
                        cmd_busy    <= 1'b1;
                        state_reg   <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (!sd_init_done || sd_init_err) begin
                        cmd_err   <= 1'b1;
                        err_code  <= ERR_NOT_INIT;
                        cmd_busy  <= 1'b0;
                        state_reg <= S_ERR;
                    end else if (count_reg == '0) begin
                        cmd_done  <= 1'b1;
                        cmd_busy  <= 1'b0;
                        state_reg <= S_DONE;
                    end else begin
                        state_reg <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!sd_busy) begin
                        addr_reg     <= addr_next;
                        timer_reg    <= '0;
                        byte_cnt_reg <= '0;
                        if (write_reg) begin
                            sd_wr_start <= 1'b1;
                            state_reg   <= S_WAIT_WR;
                        end else begin
                            sd_rd_start <= 1'b1;
                            state_reg   <= S_WAIT_RD;
                        end
                    end
                end
                S_WAIT_RD: begin
                    byte_cnt_reg <= byte_cnt_next;
                    if (sd_rd_done) begin
                        if (byte_cnt_next != 10'(SECTOR_BYTES)) begin
                            cmd_err   <= 1'b1;
                            err_code  <= ERR_SHORT;
                            cmd_busy  <= 1'b0;
                            state_reg <= S_ERR;
                        end else begin
                            state_reg <= S_NEXT;
                        end
                    end else if (timeout_hit) begin
                        cmd_err   <= 1'b1;
                        err_code  <= ERR_TIMEOUT;
                        cmd_busy  <= 1'b0;
                        state_reg <= S_ERR;
                    end else begin
                        timer_reg <= timer_reg + 32'd1;
                    end
                end
                S_WAIT_WR: begin
                    if (sd_wr_done) begin
`ifdef SD_XFER_VERIFY_EN
                        state_reg <= S_VFY_ISSUE;
`else
                        state_reg <= S_NEXT;
`endif
                    end else if (timeout_hit) begin
                        cmd_err   <= 1'b1;
                        err_code  <= ERR_TIMEOUT;
                        cmd_busy  <= 1'b0;
                        state_reg <= S_ERR;
                    end else begin
                        timer_reg <= timer_reg + 32'd1;
                    end
                end
`ifdef SD_XFER_VERIFY_EN
                S_VFY_ISSUE: begin
                    if (!sd_busy) begin
                        sd_rd_start  <= 1'b1;
                        timer_reg    <= '0;
                        byte_cnt_reg <= '0;
                        mismatch_reg <= 1'b0;
                        state_reg    <= S_VFY_WAIT;
                    end
                end
                S_VFY_WAIT: begin
                    byte_cnt_reg <= byte_cnt_next;
                    if (byte_bad) mismatch_reg <= 1'b1;
                    if (sd_rd_done) begin
                        if (mismatch_reg || byte_bad) begin
                            cmd_err   <= 1'b1;
                            err_code  <= ERR_VERIFY;
                            cmd_busy  <= 1'b0;
                            state_reg <= S_ERR;
                        end else if (byte_cnt_next != 10'(SECTOR_BYTES)) begin
                            cmd_err   <= 1'b1;
                            err_code  <= ERR_SHORT;
                            cmd_busy  <= 1'b0;
                            state_reg <= S_ERR;
                        end else begin
                            state_reg <= S_NEXT;
                        end
                    end else if (timeout_hit) begin
                        cmd_err   <= 1'b1;
                        err_code  <= ERR_TIMEOUT;
                        cmd_busy  <= 1'b0;
                        state_reg <= S_ERR;
                    end else begin
                        timer_reg <= timer_reg + 32'd1;
                    end
                end
`endif
                S_NEXT: begin
                    blocks_done <= blocks_done + CNT_W'(1);
                    if (last_blk) begin
                        cmd_done  <= 1'b1;
                        cmd_busy  <= 1'b0;
                        state_reg <= S_DONE;
                    end else begin
                        blk_idx_reg <= blk_idx_reg + CNT_W'(1);
                        state_reg   <= S_ISSUE;
                    end
                end
                S_DONE:  state_reg <= S_IDLE;
                S_ERR:   state_reg <= S_IDLE;
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_block_xfer.sv
// Directed testbench for sd_block_xfer with a small SD controller BFM.
module tb_sd_block_xfer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_start = 1'b0;
    logic        cmd_write = 1'b0;
    logic [10:0] cmd_lba_off = '0;
    logic [3:0]  cmd_count = '0;
    logic [7:0]  cmd_fill = '0;
    logic        cmd_busy, cmd_done, cmd_err;
    logic [2:0]  err_code;
    logic [3:0]  blocks_done;
    logic [3:0]  cap_addr = '0;
    logic [7:0]  cap_data;
    logic        sd_init_done = 1'b1;
    logic        sd_init_err = 1'b0;
    logic        sd_busy = 1'b0;
    logic        sd_rd_start;
    logic [31:0] sd_rd_addr;
    logic [7:0]  sd_rd_data = '0;
    logic        sd_rd_valid = 1'b0;
    logic        sd_rd_done = 1'b0;
    logic        sd_wr_start;
    logic [31:0] sd_wr_addr;
    logic [7:0]  sd_wr_data;
    logic        sd_wr_done = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    // BFM behaviour: 0 full block, 1 short (511 bytes), 2 never answers
    int bfm_mode = 0;
    int bfm_pattern = 0;     // 0: byte i = i%256, 1: byte = sd_wr_data
    int bfm_corrupt = -1;    // byte index to corrupt when bfm_pattern==1

    int rd_starts = 0;
    int wr_starts = 0;
    logic [31:0] wr_addr_q[$];

    always #5 clk = ~clk;

    sd_block_xfer #(
        .BASE_LBA(20), .ADDR_W(11), .CNT_W(4), .CAP_BYTES(16), .TIMEOUT_CYC(1000)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_start(cmd_start), .cmd_write(cmd_write), .cmd_lba_off(cmd_lba_off),
        .cmd_count(cmd_count), .cmd_fill(cmd_fill),
        .cmd_busy(cmd_busy), .cmd_done(cmd_done), .cmd_err(cmd_err),
        .err_code(err_code), .blocks_done(blocks_done),
        .cap_addr(cap_addr), .cap_data(cap_data),
        .sd_init_done(sd_init_done), .sd_init_err(sd_init_err), .sd_busy(sd_busy),
        .sd_rd_start(sd_rd_start), .sd_rd_addr(sd_rd_addr), .sd_rd_data(sd_rd_data),
        .sd_rd_valid(sd_rd_valid), .sd_rd_done(sd_rd_done),
        .sd_wr_start(sd_wr_start), .sd_wr_addr(sd_wr_addr), .sd_wr_data(sd_wr_data),
        .sd_wr_done(sd_wr_done)
    );

    // Monitor: count start pulses and log write addresses.
    always @(negedge clk) begin
        if (sd_rd_start) rd_starts++;
        if (sd_wr_start) begin
            wr_starts++;
            wr_addr_q.push_back(sd_wr_addr);
        end
    end

    task automatic bfm_read();
        int n;
        if (bfm_mode == 2) return;
        n = (bfm_mode == 1) ? 511 : 512;
        for (int i = 0; i < n; i++) begin
            if (!rst_n) begin
                sd_rd_valid = 1'b0;
                return;
            end
            sd_rd_valid = 1'b1;
            if (bfm_pattern == 1)
                sd_rd_data = (i == bfm_corrupt) ? ~sd_wr_data : sd_wr_data;
            else
                sd_rd_data = 8'(i);
            @(posedge clk); #1;
        end
        sd_rd_valid = 1'b0;
        if (!rst_n) return;
        sd_rd_done = 1'b1;
        @(posedge clk); #1;
        sd_rd_done = 1'b0;
    endtask

    task automatic bfm_write();
        if (bfm_mode == 2) return;
        repeat (3) @(posedge clk);
        #1;
        if (!rst_n) return;
        sd_wr_done = 1'b1;
        @(posedge clk); #1;
        sd_wr_done = 1'b0;
    endtask

    // SD controller BFM: answers each start pulse.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rst_n && sd_rd_start)      bfm_read();
            else if (rst_n && sd_wr_start) bfm_write();
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse cmd_start for one cycle; returns at the edge that sampled it + 1.
    task automatic start_cmd(input logic w, input logic [10:0] off,
                             input logic [3:0] cnt, input logic [7:0] fill);
        cmd_write = w; cmd_lba_off = off; cmd_count = cnt; cmd_fill = fill;
        cmd_start = 1'b1;
        @(posedge clk); #1;
        cmd_start = 1'b0;
    endtask

    // Bounded wait for completion; reports whether it ended with cmd_done.
    task automatic wait_end(input string tag, output bit done_seen);
        bit seen;
        seen = 1'b0;
        done_seen = 1'b0;
        for (int i = 0; i < 5000 && !seen; i++) begin
            @(negedge clk);
            if (cmd_done || cmd_err) begin
                seen = 1'b1;
                done_seen = cmd_done;
            end
        end
        chk({tag, "_ended"}, 32'(seen), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        int rs0, ws0, wq0;
        bit dn;

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #3;
        chk("reset_outputs", {cmd_busy, cmd_done, cmd_err, err_code, blocks_done,
                              sd_rd_start, sd_wr_start, sd_wr_data, cap_data}, 32'd0);
        chk("reset_addr", sd_rd_addr | sd_wr_addr, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single-block read at offset 3 with start latency check
        rs0 = rd_starts;
        start_cmd(1'b0, 11'd3, 4'd1, 8'h00);
        chk("rd_busy_after_accept", 32'(cmd_busy), 32'd1);
        @(posedge clk); #1;
        chk("rd_no_start_cycle1", 32'(sd_rd_start), 32'd0);
        @(posedge clk); #1;
        chk("rd_start_cycle2", 32'(sd_rd_start), 32'd1);
        chk("rd_addr", sd_rd_addr, 32'd23);
        wait_end("rd", dn);
        chk("rd_done_pulse", 32'(dn), 32'd1);
        chk("rd_done_width", 32'(cmd_done), 32'd0);
        chk("rd_busy_low", 32'(cmd_busy), 32'd0);
        chk("rd_blocks_done", 32'(blocks_done), 32'd1);
        chk("rd_start_count", 32'(rd_starts - rs0), 32'd1);
        cap_addr = 4'd5;
        @(posedge clk); #1;
        chk("cap_data_5", 32'(cap_data), 32'h05);
        cap_addr = 4'd15;
        @(posedge clk); #1;
        chk("cap_data_15", 32'(cap_data), 32'h0F);
        $display("txn read off=3 cnt=1: done=%0d blocks=%0d", dn, blocks_done);

        // Four-block write with a stray cmd_start while busy
        bfm_pattern = 1;
        rs0 = rd_starts; ws0 = wr_starts; wq0 = wr_addr_q.size();
        start_cmd(1'b1, 11'd0, 4'd4, 8'h37);
        repeat (5) @(posedge clk);
        #1;
        cmd_count = 4'd1; cmd_start = 1'b1;
        @(posedge clk); #1;
        cmd_start = 1'b0;
        chk("wr_data_stable", 32'(sd_wr_data), 32'h37);
        wait_end("wr", dn);
        chk("wr_done_pulse", 32'(dn), 32'd1);
        chk("wr_blocks_done", 32'(blocks_done), 32'd4);
        chk("wr_start_count", 32'(wr_starts - ws0), 32'd4);
        if (wr_addr_q.size() >= wq0 + 4) begin
            chk("wr_addr_first", wr_addr_q[wq0], 32'd20);
            chk("wr_addr_last", wr_addr_q[wq0 + 3], 32'd23);
        end
`ifdef SD_XFER_VERIFY_EN
        chk("wr_verify_reads", 32'(rd_starts - rs0), 32'd4);
`else
        chk("wr_no_reads", 32'(rd_starts - rs0), 32'd0);
`endif
        chk("wr_data_after", 32'(sd_wr_data), 32'h37);
        $display("txn write off=0 cnt=4 fill=0x37: done=%0d blocks=%0d", dn, blocks_done);
        bfm_pattern = 0;

        // Zero-block command completes without SD access
        rs0 = rd_starts; ws0 = wr_starts;
        start_cmd(1'b0, 11'd7, 4'd0, 8'h00);
        @(posedge clk); #1;
        chk("zero_done", 32'({cmd_done, cmd_busy, cmd_err}), 32'b100);
        chk("zero_blocks", 32'(blocks_done), 32'd0);
        chk("zero_no_access", 32'((rd_starts - rs0) + (wr_starts - ws0)), 32'd0);
        $display("txn read cnt=0: blocks=%0d", blocks_done);
        @(posedge clk); #1;

        // Controller not initialised
        sd_init_done = 1'b0;
        rs0 = rd_starts;
        start_cmd(1'b0, 11'd0, 4'd1, 8'h00);
        @(posedge clk); #1;
        chk("noinit_err", 32'({cmd_err, cmd_busy, cmd_done}), 32'b100);
        chk("noinit_code", 32'(err_code), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("noinit_no_start", 32'(rd_starts - rs0), 32'd0);
        $display("txn read no-init: err=%0d code=%0d", cmd_err, err_code);
        sd_init_done = 1'b1;

        // Timeout: BFM never answers the read
        bfm_mode = 2;
        start_cmd(1'b0, 11'd1, 4'd1, 8'h00);
        chk("err_cleared_on_accept", 32'({cmd_err, err_code}), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("to_start", 32'(sd_rd_start), 32'd1);
        repeat (999) @(posedge clk);
        #1;
        chk("to_not_yet", 32'({cmd_err, cmd_busy}), 32'b01);
        @(posedge clk); #1;
        chk("to_err", 32'({cmd_err, cmd_busy}), 32'b10);
        chk("to_code", 32'(err_code), 32'd2);
        $display("txn read timeout: err=%0d code=%0d", cmd_err, err_code);
        bfm_mode = 0;
        @(posedge clk); #1;

        // Short block: 511 bytes then done
        bfm_mode = 1;
        start_cmd(1'b0, 11'd2, 4'd2, 8'h00);
        wait_end("short", dn);
        chk("short_code", 32'({dn, cmd_err, err_code}), {27'd0, 1'b0, 1'b1, 3'd3});
        chk("short_blocks", 32'(blocks_done), 32'd0);
        $display("txn read short: err=%0d code=%0d", cmd_err, err_code);
        bfm_mode = 0;

`ifdef SD_XFER_VERIFY_EN
        // Readback corrupted at byte 100
        bfm_pattern = 1; bfm_corrupt = 100;
        start_cmd(1'b1, 11'd5, 4'd1, 8'hA5);
        wait_end("vfy", dn);
        chk("vfy_code", 32'({cmd_err, err_code}), {28'd0, 1'b1, 3'd4});
        chk("vfy_blocks", 32'(blocks_done), 32'd0);
        $display("txn write verify corrupt: err=%0d code=%0d", cmd_err, err_code);
        bfm_pattern = 0; bfm_corrupt = -1;
`endif

        // Reset in the middle of a read block
        start_cmd(1'b0, 11'd4, 4'd3, 8'h00);
        repeat (40) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {cmd_busy, cmd_done, cmd_err, err_code, blocks_done,
                               sd_rd_start, sd_wr_start, sd_wr_data, cap_data}, 32'd0);
        chk("midrst_addr", sd_rd_addr, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        rs0 = rd_starts;
        repeat (20) @(posedge clk);
        #1;
        chk("midrst_no_start", 32'(rd_starts - rs0), 32'd0);
        chk("midrst_idle", 32'(cmd_busy), 32'd0);
        $display("txn reset mid-block: busy=%0d", cmd_busy);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
